alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 130 +++++++++++++
 tb/tb_alu_issue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: single-issue RV32I ALU sequencer (decode -> EXEC -> DONE) driving an external combinational ALU.
// Handles R-type, a subset of I-type ALU ops, LUI and conditional branches.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        br_taken,
    output logic        illegal
);
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    localparam logic [3:0] XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] d_a, d_b;
    logic [3:0]  d_op;
    logic        d_ill, d_wb, d_br;
    logic        wb_cls, br_cls, br_lt, br_inv;
    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    function automatic logic [3:0] op_of(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    return alt ? SUB : ADD;
            3'd1:    return SLL;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return XOR;
            3'd5:    return alt ? SRA : SRL;
            3'd6:    return OR;
            default: return AND;
        endcase
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? EXEC : IDLE;
            EXEC:    state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        d_a   = rs1_data;
        d_b   = rs2_data;
        d_op  = ADD;
        d_ill = 1'b1;
        d_wb  = 1'b0;
        d_br  = 1'b0;
        case (opc)
            7'b0110011: begin
                d_wb  = 1'b1;
                d_op  = op_of(f3, inst[30]);
                d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'b0010011: begin
                d_wb  = 1'b1;
                d_b   = {{20{inst[31]}}, inst[31:20]};
                // bit 30 of an ADDI immediate is data, not an op selector
                d_op  = op_of(f3, f3 == 3'd5 && inst[30]);
                d_ill = !(f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) ||
                          (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
            end
            7'b0110111: begin
                d_wb  = 1'b1;
                d_a   = '0;
                d_b   = {inst[31:12], 12'b0};
                d_ill = 1'b0;
            end
            7'b1100011: begin
                d_br  = 1'b1;
                d_op  = f3[2] ? (f3[1] ? SLTU : SLT) : SUB;
                d_ill = f3[2:1] == 2'b01;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            wb_rd    <= '0;
            illegal  <= 1'b0;
            wb_cls   <= 1'b0;
            br_cls   <= 1'b0;
            br_lt    <= 1'b0;
            br_inv   <= 1'b0;
            wb_en    <= 1'b0;
            wb_data  <= '0;
            br_taken <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            alu_a   <= d_a;
            alu_b   <= d_b;
            alu_op  <= d_op;
            wb_rd   <= inst[11:7];
            illegal <= d_ill;
            wb_cls  <= d_wb && !d_ill;
            br_cls  <= d_br && !d_ill;
            br_lt   <= f3[2];
            br_inv  <= f3[0];
        end else if (state == EXEC) begin
            // odd funct3 branches (BNE/BGE/BGEU) invert the base condition
            wb_en    <= wb_cls && wb_rd != 5'd0;
            wb_data  <= wb_cls ? alu_res : '0;
            br_taken <= br_cls && ((br_lt ? alu_res[0] : alu_zero) ^ br_inv);
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized bench for alu_issue with an architectural RV32I reference model
// and an ALU model closing the loop on alu_a/alu_b/alu_op.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst, rs1_data, rs2_data, alu_a, alu_b, alu_res, wb_data;
    logic [3:0]  alu_op;
    logic        alu_zero, wb_en, br_taken, illegal;
    logic [4:0]  wb_rd;
    int          total = 0;
    int          bad = 0;

    typedef struct packed {
        logic        ill;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        br;
        logic [3:0]  op;
    } exp_t;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .br_taken(br_taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // external combinational ALU
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0: alu_res = alu_a + alu_b;
            4'd1: alu_res = alu_a - alu_b;
            4'd2: alu_res = alu_a << alu_b[4:0];
            4'd3: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd4: alu_res = {31'b0, alu_a < alu_b};
            4'd5: alu_res = alu_a ^ alu_b;
            4'd6: alu_res = alu_a >> alu_b[4:0];
            4'd7: alu_res = $signed(alu_a) >>> alu_b[4:0];
            4'd8: alu_res = alu_a | alu_b;
            4'd9: alu_res = alu_a & alu_b;
            default: ;
        endcase
    end
    assign alu_zero = alu_res == 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // architectural result of one instruction
    function automatic exp_t model_of(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  sh;
        e = '0;
        e.ill = 1'b1;
        e.rd = i[11:7];
        f7 = i[31:25];
        f3 = i[14:12];
        imm = {{20{i[31]}}, i[31:20]};
        sh = i[24:20];
        case (i[6:0])
            7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                e.ill = 1'b0;
                case (f3)
                    3'd0: if (f7[5]) begin e.data = a - b; e.op = 4'd1; end
                          else begin e.data = a + b; e.op = 4'd0; end
                    3'd1: begin e.data = a << b[4:0]; e.op = 4'd2; end
                    3'd2: begin e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.op = 4'd3; end
                    3'd3: begin e.data = (a < b) ? 32'd1 : 32'd0; e.op = 4'd4; end
                    3'd4: begin e.data = a ^ b; e.op = 4'd5; end
                    3'd5: if (f7[5]) begin e.data = $signed(a) >>> b[4:0]; e.op = 4'd7; end
                          else begin e.data = a >> b[4:0]; e.op = 4'd6; end
                    3'd6: begin e.data = a | b; e.op = 4'd8; end
                    default: begin e.data = a & b; e.op = 4'd9; end
                endcase
            end
            7'b0010011: begin
                if (f3 == 3'd0) begin e.ill = 1'b0; e.data = a + imm; e.op = 4'd0; end
                if (f3 == 3'd1 && f7 == 7'h00) begin e.ill = 1'b0; e.data = a << sh; e.op = 4'd2; end
                if (f3 == 3'd5 && f7 == 7'h00) begin e.ill = 1'b0; e.data = a >> sh; e.op = 4'd6; end
                if (f3 == 3'd5 && f7 == 7'h20) begin e.ill = 1'b0; e.data = $signed(a) >>> sh; e.op = 4'd7; end
            end
            7'b0110111: begin e.ill = 1'b0; e.data = {i[31:12], 12'b0}; e.op = 4'd0; end
            7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) begin
                e.ill = 1'b0;
                case (f3)
                    3'd0: begin e.br = a == b; e.op = 4'd1; end
                    3'd1: begin e.br = a != b; e.op = 4'd1; end
                    3'd4: begin e.br = $signed(a) < $signed(b); e.op = 4'd3; end
                    3'd5: begin e.br = $signed(a) >= $signed(b); e.op = 4'd3; end
                    3'd6: begin e.br = a < b; e.op = 4'd4; end
                    default: begin e.br = a >= b; e.op = 4'd4; end
                endcase
                return e;
            end
            default: ;
        endcase
        e.wb = !e.ill && e.rd != 5'd0;
        return e;
    endfunction

    // transaction timeline as seen from the bus: accept, one EXEC edge, then hold until out_ready
    exp_t exp_q;
    logic busy;
    logic done_phase;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done_phase <= 1'b0;
        end else if (!busy) begin
            if (in_valid) begin
                busy <= 1'b1;
                done_phase <= 1'b0;
                exp_q <= model_of(inst, rs1_data, rs2_data);
            end
        end else if (!done_phase) begin
            done_phase <= 1'b1;
        end else if (out_ready) begin
            busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctl", {18'b0, in_ready, out_valid, wb_en, br_taken, illegal, alu_op, wb_rd}, {18'b0, 1'b1, 13'b0});
            check("rst_data", alu_a | alu_b | wb_data, 32'd0);
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, !busy});
            check("out_valid", {31'b0, out_valid}, {31'b0, busy && done_phase});
            if (busy && done_phase) begin
                check("illegal", {31'b0, illegal}, {31'b0, exp_q.ill});
                check("wb_en", {31'b0, wb_en}, {31'b0, exp_q.wb});
                check("wb_data", wb_data, exp_q.data);
                check("br_taken", {31'b0, br_taken}, {31'b0, exp_q.br});
                if (exp_q.wb) check("wb_rd", {27'b0, wb_rd}, {27'b0, exp_q.rd});
                if (!exp_q.ill) check("alu_op", {28'b0, alu_op}, {28'b0, exp_q.op});
            end
        end
    end

    logic        s_ov, s_wb, s_br, s_ill;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [3:0]  s_op;

    // starts and ends on a negedge with the DUT idle
    task automatic txn(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input int hold);
        in_valid = 1'b1;
        inst = i;
        rs1_data = a;
        rs2_data = b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'($urandom % 2);
        inst = $urandom;
        rs1_data = $urandom;
        rs2_data = $urandom;
        @(posedge clk);
        @(negedge clk);
        {s_ov, s_wb, s_br, s_ill, s_rd, s_data, s_op} = {out_valid, wb_en, br_taken, illegal, wb_rd, wb_data, alu_op};
        repeat (hold) begin
            in_valid = 1'($urandom % 2);
            inst = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'($urandom % 2);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0110111;
            3: r[6:0] = 7'b1100011;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        exp_t e;
        logic ov_seen;
        logic [31:0] a, b;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        inst = '0;
        rs1_data = '0;
        rs2_data = '0;

        e = model_of(32'h002081B3, 32'd5, 32'd7);
        check("model_add_data", e.data, 32'd12);
        check("model_add_rd", {27'b0, e.rd}, 32'd3);
        check("model_add_op", {28'b0, e.op}, 32'd0);
        e = model_of(32'h40435293, 32'h80000000, 32'd0);
        check("model_srai_data", e.data, 32'hF8000000);
        check("model_srai_op", {28'b0, e.op}, 32'd7);
        e = model_of(32'h00208063, 32'h1234, 32'h1234);
        check("model_beq_t", {31'b0, e.br}, 32'd1);
        e = model_of(32'h00208063, 32'h1234, 32'h1235);
        check("model_beq_nt", {31'b0, e.br}, 32'd0);
        e = model_of(32'h0000007F, 32'd1, 32'd2);
        check("model_ill", {31'b0, e.ill}, 32'd1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(32'h002081B3, 32'd5, 32'd7, 3);
        check("add_ov", {31'b0, s_ov}, 32'd1);
        check("add_wb", {31'b0, s_wb}, 32'd1);
        check("add_rd", {27'b0, s_rd}, 32'd3);
        check("add_data", s_data, 32'd12);
        check("add_op", {28'b0, s_op}, 32'd0);

        txn(32'h40435293, 32'h80000000, 32'd0, 0);
        check("srai_op", {28'b0, s_op}, 32'd7);
        check("srai_rd", {27'b0, s_rd}, 32'd5);
        check("srai_data", s_data, 32'hF8000000);

        txn(32'h00208063, 32'h1234, 32'h1234, 1);
        check("beq_t", {31'b0, s_br}, 32'd1);
        check("beq_wb", {31'b0, s_wb}, 32'd0);
        txn(32'h00208063, 32'h1234, 32'h1235, 0);
        check("beq_nt", {31'b0, s_br}, 32'd0);

        txn(32'h0000007F, 32'd3, 32'd4, 2);
        check("ill_flag", {31'b0, s_ill}, 32'd1);
        check("ill_wb_br", {30'b0, s_wb, s_br}, 32'd0);
        check("ill_ov", {31'b0, s_ov}, 32'd1);

        // reset while the transaction sits in EXEC
        in_valid = 1'b1;
        inst = 32'h002081B3;
        rs1_data = 32'h11;
        rs2_data = 32'h22;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_ctl", {18'b0, in_ready, out_valid, wb_en, br_taken, illegal, alu_op, wb_rd}, {18'b0, 1'b1, 13'b0});
        check("arst_data", alu_a | alu_b | wb_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        check("no_ov_after_rst", {31'b0, ov_seen}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 40));
            txn(rand_inst(), a, b, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
